// File: rtl/dense_backprop_calculator_if.sv
// Request/result bundle for the dense-layer back-propagation calculator.
interface dense_backprop_calculator_if #(
   parameter int data_size = 16,
   parameter int size      = 3
);
   logic                             start;
   logic [data_size*size-1:0]        diff_z_to_z;
   logic [data_size*size*size-1:0]   weight;
   logic [data_size*size-1:0]        diff_dense;
   logic                             busy;
   logic                             done;

   modport master (output start, diff_z_to_z, weight, input diff_dense, busy, done);
   modport slave  (input start, diff_z_to_z, weight, output diff_dense, busy, done);
endinterface

// File: rtl/dense_backprop_calculator.sv
// Computes diff_dense[j] = sat(sum_i W[i][j]*dz[i] >>> frac) one weight row per clock.
module dense_backprop_calculator #(
   parameter int data_size = 16,
   parameter int size      = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   dense_backprop_calculator_if.slave  bus
);
   localparam int unsigned frac_w = data_size / 2;
   localparam int unsigned cnt_w  = (size > 1) ? $clog2(size) : 1;
   localparam int unsigned prod_w = 2 * data_size;
   localparam int unsigned acc_w  = 2 * data_size + $clog2(size) + 1;

   localparam logic signed [acc_w-1:0] sat_max =
      {{(acc_w-data_size+1){1'b0}}, {(data_size-1){1'b1}}};
   localparam logic signed [acc_w-1:0] sat_min =
      {{(acc_w-data_size+1){1'b1}}, {(data_size-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                      state;
   logic [cnt_w-1:0]            row;
   logic signed [data_size-1:0] dz_q    [size];
   logic signed [data_size-1:0] w_q     [size][size];
   logic signed [acc_w-1:0]     acc     [size];
   logic signed [prod_w-1:0]    prod    [size];
   logic signed [acc_w-1:0]     shifted [size];
   logic [data_size-1:0]        sat     [size];

   // Row products for the current counter and the rescaled/saturated accumulators
   always_comb begin
      for (int j = 0; j < size; j++) begin
         prod[j]    = prod_w'(w_q[row][j]) * prod_w'(dz_q[row]);
         shifted[j] = acc[j] >>> frac_w;
         if (shifted[j] > sat_max)
            sat[j] = {1'b0, {(data_size-1){1'b1}}};
         else if (shifted[j] < sat_min)
            sat[j] = {1'b1, {(data_size-1){1'b0}}};
         else
            sat[j] = shifted[j][data_size-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         row            <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.diff_dense <= '0;
         for (int j = 0; j < size; j++) begin
            acc[j]  <= '0;
            dz_q[j] <= '0;
            for (int i = 0; i < size; i++) w_q[i][j] <= '0;
         end
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  for (int i = 0; i < size; i++) begin
                     acc[i]  <= '0;
                     dz_q[i] <= bus.diff_z_to_z[data_size*(size-i)-1 -: data_size];
                     for (int j = 0; j < size; j++)
                        w_q[i][j] <= bus.weight[data_size*(size*size-(i*size+j))-1 -: data_size];
                  end
                  row      <= '0;
                  bus.busy <= 1'b1;
                  state    <= MAC;
               end
            end
            MAC: begin
               for (int j = 0; j < size; j++) acc[j] <= acc[j] + acc_w'(prod[j]);
               if (row == cnt_w'(size - 1)) state <= DONE;
               else                         row   <= row + cnt_w'(1);
            end
            DONE: begin
               for (int j = 0; j < size; j++)
                  bus.diff_dense[data_size*(size-j)-1 -: data_size] <= sat[j];
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dense_backprop_calculator.sv
// Randomized and directed checks of the dense back-propagation calculator against a matrix-level model.
module tb_dense_backprop_calculator;
   localparam int DW = 16;
   localparam int N  = 3;
   localparam int FR = DW / 2;
   localparam int VW = DW * N;
   localparam int MW = DW * N * N;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dense_backprop_calculator_if #(.data_size(DW), .size(N)) bus ();
   dense_backprop_calculator #(.data_size(DW), .size(N)) dut (
      .clk(clk), .reset(reset), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   // Model: pass result is fixed at acceptance; visible size+1 edges later
   int          remaining;
   logic        exp_busy, exp_done;
   logic [VW-1:0] exp_dd, pending;

   function automatic logic [VW-1:0] golden(input logic [VW-1:0] dz, input logic [MW-1:0] w);
      logic [VW-1:0] r;
      longint hi, lo;
      r  = '0;
      hi = (longint'(1) << (DW - 1)) - 1;
      lo = -hi - 1;
      for (int j = 0; j < N; j++) begin
         longint s;
         s = 0;
         for (int i = 0; i < N; i++) begin
            logic signed [DW-1:0] wv, dv;
            wv = w[DW*(N*N-(i*N+j))-1 -: DW];
            dv = dz[DW*(N-i)-1 -: DW];
            s += longint'(wv) * longint'(dv);
         end
         s = s >>> FR;
         if (s > hi) s = hi;
         if (s < lo) s = lo;
         r[DW*(N-j)-1 -: DW] = DW'(s);
      end
      return r;
   endfunction

   function automatic logic [MW-1:0] diag(input logic [DW-1:0] d, input logic [DW-1:0] o);
      logic [MW-1:0] m;
      for (int n = 0; n < N*N; n++) m[DW*(N*N-n)-1 -: DW] = ((n / N) == (n % N)) ? d : o;
      return m;
   endfunction

   function automatic logic [DW-1:0] rnd_word();
      if ($urandom_range(3) != 0) return DW'($urandom_range(2047)) - DW'(1024);
      return DW'($urandom);
   endfunction

   task automatic randomize_inputs();
      for (int k = 0; k < N; k++) bus.diff_z_to_z[DW*(N-k)-1 -: DW] = rnd_word();
      for (int n = 0; n < N*N; n++) bus.weight[DW*(N*N-n)-1 -: DW] = rnd_word();
   endtask

   task automatic model_clear();
      remaining = 0; exp_busy = 1'b0; exp_done = 1'b0; exp_dd = '0; pending = '0;
   endtask

   task automatic model_edge();
      if (reset) model_clear();
      else if (remaining == 0) begin
         exp_done = 1'b0;
         if (bus.start) begin
            pending   = golden(bus.diff_z_to_z, bus.weight);
            remaining = N + 1;
            exp_busy  = 1'b1;
         end
      end else begin
         remaining--;
         exp_done = 1'b0;
         if (remaining == 0) begin
            exp_busy = 1'b0;
            exp_done = 1'b1;
            exp_dd   = pending;
         end
      end
   endtask

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, "_busy"}, VW'(bus.busy), VW'(exp_busy));
      check({tag, "_done"}, VW'(bus.done), VW'(exp_done));
      check({tag, "_dd"}, bus.diff_dense, exp_dd);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all("cyc");
   endtask

   // One pass with literal expectation; inputs are scrambled right after acceptance
   task automatic run_pass(input string name, input logic [VW-1:0] dz, input logic [MW-1:0] w,
                           input logic [VW-1:0] lit);
      int k, busy_cnt;
      logic got;
      bus.diff_z_to_z = dz;
      bus.weight      = w;
      bus.start       = 1'b1;
      step();
      bus.start = 1'b0;
      randomize_inputs();
      busy_cnt = bus.busy ? 1 : 0;
      k = 0; got = 1'b0;
      while (k < 12 && !got) begin
         step();
         k++;
         if (bus.busy) busy_cnt++;
         if (bus.done) got = 1'b1;
      end
      check({name, "_latency"}, VW'(k), VW'(N + 1));
      check({name, "_busycnt"}, VW'(busy_cnt), VW'(N + 1));
      check({name, "_value"}, bus.diff_dense, lit);
   endtask

   initial begin
      int dones;
      reset = 1'b0;
      bus.start = 1'b0; bus.diff_z_to_z = '0; bus.weight = '0;
      model_clear();
      #1 reset = 1'b1;
      #1 compare_all("reset");
      step(); step();
      reset = 1'b0;

      run_pass("identity", {16'h0100, 16'h0200, 16'h0300}, diag(16'h0100, 16'h0000),
               {16'h0100, 16'h0200, 16'h0300});
      run_pass("allone", {16'h0100, 16'h0200, 16'h0300}, diag(16'h0100, 16'h0100),
               {3{16'h0600}});
      run_pass("negdiag", {3{16'h0200}}, diag(16'hFF00, 16'h0000), {3{16'hFE00}});
      run_pass("trunc_pos", {3{16'h0001}}, diag(16'h0080, 16'h0000), {3{16'h0000}});
      run_pass("trunc_neg", {3{16'hFFFF}}, diag(16'h0080, 16'h0000), {3{16'hFFFF}});
      run_pass("sat_hi", {3{16'h6400}}, diag(16'h6400, 16'h6400), {3{16'h7FFF}});
      run_pass("sat_lo", {3{16'h9C00}}, diag(16'h6400, 16'h6400), {3{16'h8000}});

      // Start held high: new passes only from IDLE, one done per N+2 cycles
      randomize_inputs();
      bus.start = 1'b1;
      dones = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (bus.done) dones++;
         randomize_inputs();
      end
      bus.start = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (bus.done) dones++;
      end
      check("held_start_dones", VW'(dones), VW'(2));

      // Abort in the second MAC cycle: outputs clear asynchronously, no done
      randomize_inputs();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      #2 reset = 1'b1;
      model_clear();
      #1 compare_all("abort");
      step(); step();
      reset = 1'b0;
      run_pass("after_abort", {16'h0100, 16'h0200, 16'h0300}, diag(16'h0100, 16'h0000),
               {16'h0100, 16'h0200, 16'h0300});

      // Random traffic checked every cycle against the model
      for (int c = 0; c < 400; c++) begin
         randomize_inputs();
         bus.start = ($urandom_range(3) == 0);
         step();
      end
      bus.start = 1'b0;
      for (int c = 0; c < 8; c++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/dense_backprop_calculator.md
DENSE_BACKPROP_CALCULATOR -- requirements
Module: dense_backprop_calculator

Interface
REQ-001 SHALL have parameter data_size, default 16, signed fixed-point word width with data_size/2 fraction bits.
REQ-002 SHALL have parameter size, default 3, the number of neurons in both the current layer and the previous layer (square weight matrix).
REQ-003 SHALL use one clock and an asynchronous, active-high reset: port clk (input, 1) and port reset (input, 1) are listed first.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 start  input  1  request to compute one back-propagation pass; sampled only in IDLE.
REQ-007 diff_z_to_z  input  data_size*size  per-neuron dz of the current layer; element k at [data_size*(size-k)-1 -: data_size].
REQ-008 weight  input  data_size*size*size  weight matrix; W[i][j] (current neuron i, previous neuron j) is element n=i*size+j at [data_size*(size*size-n)-1 -: data_size].
REQ-009 diff_dense  output  data_size*size  gradient toward the previous layer; element j packed as in REQ-007.
REQ-010 busy  output  1  high while a pass is in progress.
REQ-011 done  output  1  single-cycle pulse marking diff_dense updated.

Function
REQ-012 SHALL implement states IDLE, MAC, DONE.
REQ-013 IDLE: start=1 at edge E0 latches diff_z_to_z and weight into internal registers, clears all accumulators, sets row counter to 0, and enters MAC.
REQ-014 Inputs are not used after E0; changes to diff_z_to_z or weight during a pass do not affect its result.
REQ-015 MAC: each edge adds the full-precision signed product W[i][j]*dz[i] to acc[j] for all j in parallel, i = row counter, then increments the counter.
REQ-016 MAC: on the edge processing row size-1, the state moves to DONE; MAC lasts exactly size cycles (edges E1..E_size).
REQ-017 Accumulators are signed, at least 2*data_size+clog2(size) bits wide; no intermediate overflow.
REQ-018 DONE (edge E_size+1): for each j, diff_dense[j] = acc[j] arithmetic-shifted right by data_size/2 (truncation toward minus infinity), saturated to [-2^(data_size-1), 2^(data_size-1)-1]; done=1 for this cycle only; state returns to IDLE.
REQ-019 busy=1 in MAC and DONE, 0 in IDLE; done=0 in all other cycles.
REQ-020 start while busy=1 (including the DONE cycle) is ignored and not queued.
REQ-021 diff_dense holds its value from the DONE edge until the next DONE edge or reset.
REQ-022 Latency: done observed high in the cycle after edge E_size+1, i.e. size+1 clocks after start is sampled.
REQ-023 For size=1: one MAC cycle, then DONE.

Reset
REQ-024 reset=1 SHALL immediately force state IDLE, row counter 0, accumulators 0, diff_dense 0, busy 0, done 0.
REQ-025 Reset asserted during MAC or DONE aborts the pass; no done pulse is produced and diff_dense reads 0.
REQ-026 The first start after reset deassertion is accepted on the first rising edge where reset=0.

Verification (data_size=16, size=3, Q8.8)
REQ-027 Identity weights (diagonal 0x0100, others 0), dz=(0x0100,0x0200,0x0300), start one cycle -> done 4 cycles later, diff_dense=(0x0100,0x0200,0x0300).
REQ-028 All weights 0x0100, dz=(0x0100,0x0200,0x0300) -> every element 0x0600; busy high for exactly 4 cycles.
REQ-029 Diagonal weights 0xFF00 (-1.0), dz=0x0200 each -> diff_dense=(0xFE00,0xFE00,0xFE00); dz=0x0001, W diag 0x0080 -> 0x0000 (truncation toward minus infinity); dz=0xFFFF, W diag 0x0080 -> 0xFFFF.
REQ-030 All weights 0x6400, dz=0x6400 each -> each element saturates to 0x7FFF; with dz=0x9C00 each -> 0x8000.
REQ-031 Start held high continuously for 10 cycles -> passes begin only in IDLE, one done every 5 cycles (4 busy cycles + 1 IDLE cycle); changing weight after start does not change the result.
REQ-032 Complete one pass, then assert reset during the second MAC cycle of the next pass -> busy, done and diff_dense go to 0 without waiting for a clock edge; no done pulse; the next start yields the correct result.
